conv2d_linebuf_stream: RTL and testbench
========================================

// Module: conv2d_linebuf_stream
// PURPOSE
//  Parametrised streaming KxK 2-D convolution engine. Replaces the fixed 14x14 / 3x3 conv.
//  - Pixels arrive once, in raster order: (K-1) line buffers plus a KxK window register.
//  - Weights are captured on the first K*K accepted beats of a frame.
//  - One result per valid window position (no padding), at fixed latency.
//  - Sits between the IFM source and the OFM sink of the conv datapath.
// PARAMETERS
//  DATA_W  16  pixel and weight width
//  IMG_W   14  image columns
//  IMG_H   14  image rows
//  K       3   kernel size (KxK), 2..5
//  OUT_W   2*DATA_W+$clog2(K*K) (=36)  result width; full precision, no overflow
//  Legal configurations satisfy (K-1)*IMG_W+K-1 >= K*K-1, so all weights are in before the first window.
// PORTS
//  clk         in   1       clock; all logic on its rising edge
//  rst         in   1       synchronous reset, active high
//  in_valid    in   1       beat qualifier for in_ifm / in_weight
//  in_ifm      in   DATA_W  pixel, raster order (row-major)
//  in_weight   in   DATA_W  weight; sampled on frame beats 0..K*K-1 only
//  out_valid   out  1       out_ofm qualifier
//  out_ofm     out  OUT_W   convolution result; 0 when out_valid=0
//  frame_done  out  1       1-cycle pulse, coincident with the last out_valid of a frame
// BEHAVIOUR
//  Reset: sync active-high rst, applied at any time, including mid-frame.
//  - State returns to IDLE; row/col/beat counters are cleared; the weight registers are cleared.
//  - The valid pipe is flushed: out_valid=0, out_ofm=0, frame_done=0 on the cycle after rst is sampled.
//  - Line-buffer contents are not cleared; they are don't-care because they are overwritten before use.
//  State machine:
//  - IDLE -> STREAM on in_valid. That beat is pixel (0,0) and weight 0.
//  - STREAM -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
//  - DRAIN lasts 2 cycles, then returns to IDLE.
//  - in_valid during DRAIN is dropped: no state change, no capture. The next frame starts from IDLE.
//  Bubbles: in_valid may be low for any number of cycles inside a frame; counters hold, no output is generated.
//  Counters: col wraps IMG_W-1 -> 0 and increments row; beat counter saturates at K*K.
//  Weights: w[i*K+j] multiplies window row i (0 = oldest line), column j (0 = leftmost).
//  Output condition: accepting pixel (r,c) with r>=K-1 and c>=K-1 completes a window. No window is formed across a row wrap.
//  Latency: fixed 2 edges from acceptance, independent of bubbles.
//  - Edge T: line shift and window load.
//  - Edge T+1: products and adder tree.
//  - Edge T+2: out_ofm and out_valid registered.
//  Per frame: exactly (IMG_W-K+1)*(IMG_H-K+1) outputs (=144), in raster order.
//  Arithmetic: unsigned multiply, DATA_W x DATA_W -> 2*DATA_W, summed at OUT_W. No truncation or saturation.
// CONFIGURATION
//  CONV_SIGNED_EN defined:
//  - pixels, weights and out_ofm are two's complement; products are sign-extended to OUT_W before summation.
//  CONV_SIGNED_EN undefined:
//  - all operands are unsigned and zero-extended.
//  No other behaviour differs.
// TESTING
//  1 14x14 all 1s, weights all 1 -> 144 out_valid beats, each out_ofm=9; frame_done on the 144th.
//  2 pixel(r,c)=r*14+c, w4=1 and others 0 -> out_ofm=(r+1)*14+(c+1) for r,c in 0..11.
//    First output 15, 2 edges after pixel 30 is accepted.
//  3 Test 2 stimulus with in_valid randomly low 50% of cycles -> identical output sequence.
//    Each out_valid comes exactly 2 edges after its completing pixel; no beat is lost or duplicated.
//  4 Pixels and weights all 0xFFFF (unsigned) -> every out_ofm=36'h8_FFEE_0009.
//  5 rst pulsed after pixel 100, then a full test-1 frame -> outputs:
//    - no out_valid from the aborted frame after rst;
//    - then 144 x 9 from the new frame; new weights captured.
//  6 CONV_SIGNED_EN: pixels 0xFFFF (-1), weights 1 -> out_ofm=36'hF_FFFF_FFF7 (-9).
//    The same stimulus without the macro gives 36'h0_0008_FFF7.

Source files
------------

// File: rtl/conv2d_linebuf_stream.sv
// Streaming KxK 2-D convolution: (K-1) line buffers, KxK window, products and adder tree, registered output.
// Define CONV_SIGNED_EN to treat pixels, weights and results as two's complement.
module conv2d_linebuf_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 14,
    parameter int IMG_H  = 14,
    parameter int K      = 3,
    parameter int OUT_W  = 2*DATA_W + $clog2(K*K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_ifm,
    input  logic [DATA_W-1:0] in_weight,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_ofm,
    output logic              frame_done
);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int KK     = K*K;
    localparam int BEAT_W = $clog2(KK+1);
    localparam int EXT_W  = OUT_W - 2*DATA_W;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               drain_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [BEAT_W-1:0]  beat;
    logic               accept, last_pix, win_done;
    logic [DATA_W-1:0]  w_q [KK];
    logic [DATA_W-1:0]  lb [K-1][IMG_W];
    logic [DATA_W-1:0]  col_vec [K];
    logic [DATA_W-1:0]  win_p0 [K][K];
    logic               vld_p0, last_p0, vld_p1, last_p1, vld_p2, done_p2;
    logic [OUT_W-1:0]   tree_sum, sum_p1, ofm_p2;

    function automatic logic [OUT_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef CONV_SIGNED_EN
        logic signed [2*DATA_W-1:0] p;
        p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        return {{EXT_W{p[2*DATA_W-1]}}, p};
`else
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return {{EXT_W{1'b0}}, p};
`endif
    endfunction

    // Beats offered while draining are dropped, not queued.
    assign accept   = in_valid && (state_q != DRAIN);
    assign last_pix = (row == ROW_W'(IMG_H-1)) && (col == COL_W'(IMG_W-1));
    assign win_done = accept && (row >= ROW_W'(K-1)) && (col >= COL_W'(K-1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = STREAM;
            STREAM:  if (accept && last_pix) state_d = DRAIN;
            DRAIN:   if (drain_cnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            beat <= '0;
        end else if (accept) begin
            if (last_pix) begin
                col  <= '0;
                row  <= '0;
                beat <= '0;
            end else begin
                if (col == COL_W'(IMG_W-1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (beat != BEAT_W'(KK)) beat <= beat + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) w_q[i] <= '0;
        end else if (accept && (beat < BEAT_W'(KK))) begin
            w_q[beat] <= in_weight;
        end
    end

    // Column entering the window: oldest line first, incoming pixel last.
    always_comb begin
        for (int i = 0; i < K-1; i++) col_vec[i] = lb[i][col];
        col_vec[K-1] = in_ifm;
    end

    // Stage p0: line shift and window load on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K-2; i++) lb[i][col] <= lb[i+1][col];
            lb[K-2][col] <= in_ifm;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) win_p0[i][j] <= win_p0[i][j+1];
                win_p0[i][K-1] <= col_vec[i];
            end
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                tree_sum = tree_sum + mul_ext(win_p0[i][j], w_q[i*K+j]);
    end

    // Stage p1: products and adder tree; stage p2: output register
    always_ff @(posedge clk) begin
        sum_p1 <= tree_sum;
        ofm_p2 <= sum_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            done_p2 <= 1'b0;
        end else begin
            vld_p0  <= win_done;
            last_p0 <= accept && last_pix;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0 && vld_p0;
            vld_p2  <= vld_p1;
            done_p2 <= last_p1 && vld_p1;
        end
    end

    assign out_valid  = vld_p2;
    assign out_ofm    = vld_p2 ? ofm_p2 : '0;
    assign frame_done = done_p2;

endmodule

// File: tb/tb_conv2d_linebuf_stream.sv
// Bench for conv2d_linebuf_stream: directed frames with random data, checked against a window-sum model.
module tb_conv2d_linebuf_stream;
    localparam int DATA_W = 16;
    localparam int IMG_W  = 14;
    localparam int IMG_H  = 14;
    localparam int K      = 3;
    localparam int OUT_W  = 2*DATA_W + $clog2(K*K);
    localparam int NPIX   = IMG_W*IMG_H;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_ifm;
    logic [DATA_W-1:0] in_weight;
    logic              out_valid;
    logic [OUT_W-1:0]  out_ofm;
    logic              frame_done;

    conv2d_linebuf_stream #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ifm(in_ifm), .in_weight(in_weight),
        .out_valid(out_valid), .out_ofm(out_ofm), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               due;
        bit               last;
    } exp_t;

    exp_t              q[$];
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;
    int                n_out = 0;
    logic [DATA_W-1:0] img [IMG_H][IMG_W];
    logic [DATA_W-1:0] wts [K*K];
    logic [OUT_W-1:0]  first_ofm;
    bit                first_seen;
    logic [OUT_W-1:0]  want6;

    function automatic longint ext(input logic [DATA_W-1:0] x);
`ifdef CONV_SIGNED_EN
        return longint'($signed(x));
`else
        return longint'(x);
`endif
    endfunction

    function automatic logic [OUT_W-1:0] win_sum(input int r0, input int c0);
        longint s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += ext(img[r0+i][c0+j]) * ext(wts[i*K+j]);
        return OUT_W'(s);
    endfunction

    task automatic step(input bit r, input bit v, input logic [DATA_W-1:0] px,
                        input logic [DATA_W-1:0] wt);
        rst = r; in_valid = v; in_ifm = px; in_weight = wt;
        @(posedge clk);
        cyc++;
        #1;
        if (r) q.delete();
        vectors++;
        if (q.size() > 0 && q[0].due == cyc) begin
            assert (out_valid === 1'b1 && out_ofm === q[0].val && frame_done === q[0].last)
            else begin
                miscompares++;
                $error("FAIL out cyc=%0d: got v=%b ofm=%h done=%b, want v=1 ofm=%h done=%b",
                       cyc, out_valid, out_ofm, frame_done, q[0].val, q[0].last);
            end
            if (!first_seen) begin
                first_ofm  = out_ofm;
                first_seen = 1'b1;
            end
            n_out++;
            void'(q.pop_front());
        end else begin
            assert (out_valid === 1'b0 && out_ofm === '0 && frame_done === 1'b0)
            else begin
                miscompares++;
                $error("FAIL idle cyc=%0d: got v=%b ofm=%h done=%b, want v=0 ofm=0 done=0",
                       cyc, out_valid, out_ofm, frame_done);
            end
        end
    endtask

    // One accepted pixel k of the frame, optionally preceded by random bubbles.
    task automatic beat(input int k, input bit bub);
        int r, c;
        if (bub)
            while ($urandom_range(1, 0) == 1)
                step(1'b0, 1'b0, DATA_W'($urandom), DATA_W'($urandom));
        r = k / IMG_W;
        c = k % IMG_W;
        if (r >= K-1 && c >= K-1)
            q.push_back('{win_sum(r-K+1, c-K+1), cyc+3, k == NPIX-1});
        step(1'b0, 1'b1, img[r][c], (k < K*K) ? wts[k] : DATA_W'($urandom));
    endtask

    task automatic run_frame(input string tag, input bit bub, input int abort_at);
        n_out = 0;
        for (int k = 0; k < NPIX; k++) begin
            beat(k, bub);
            if (k == abort_at) begin
                step(1'b1, 1'b0, '0, '0);
                for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0);
                return;
            end
        end
        // Beats offered during the two drain cycles must be ignored.
        step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom));
        step(1'b0, 1'b1, DATA_W'($urandom), DATA_W'($urandom));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0);
        vectors++;
        assert (q.size() == 0 && n_out == (IMG_W-K+1)*(IMG_H-K+1))
        else begin
            miscompares++;
            $error("FAIL %s count: got %0d outputs (%0d pending), want %0d",
                   tag, n_out, q.size(), (IMG_W-K+1)*(IMG_H-K+1));
            q.delete();
        end
    endtask

    task automatic fill_const(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] w);
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = p;
        for (int i = 0; i < K*K; i++) wts[i] = w;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = DATA_W'(r*IMG_W + c);
        for (int i = 0; i < K*K; i++) wts[i] = (i == 4) ? 16'd1 : 16'd0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = DATA_W'($urandom);
        for (int i = 0; i < K*K; i++) wts[i] = DATA_W'($urandom);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ifm = '0; in_weight = '0;
        first_seen = 1'b0;
        first_ofm  = '0;
        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 16'h1234, 16'h5678);
        step(1'b0, 1'b0, '0, '0);

        fill_const(16'd1, 16'd1);
        run_frame("ones", 1'b0, -1);

        fill_ramp();
        first_seen = 1'b0;
        run_frame("ramp", 1'b0, -1);
        vectors++;
        assert (first_ofm === OUT_W'(15))
        else begin
            miscompares++;
            $error("FAIL ramp_first: got %h, want %h", first_ofm, OUT_W'(15));
        end

        run_frame("ramp_bubbles", 1'b1, -1);

        fill_const(16'hFFFF, 16'hFFFF);
        run_frame("all_ffff", 1'b0, -1);

        fill_random();
        run_frame("random_bubbles", 1'b1, -1);

        fill_random();
        run_frame("abort", 1'b0, 100);
        fill_const(16'd1, 16'd1);
        run_frame("after_reset", 1'b0, -1);

        fill_const(16'hFFFF, 16'd1);
        first_seen = 1'b0;
        run_frame("neg_ones", 1'b0, -1);
`ifdef CONV_SIGNED_EN
        want6 = 36'hF_FFFF_FFF7;
`else
        want6 = 36'h0_0008_FFF7;
`endif
        vectors++;
        assert (first_ofm === want6)
        else begin
            miscompares++;
            $error("FAIL neg_ones_const: got %h, want %h", first_ofm, want6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got cyc=%0d, want done", cyc);
        $fatal(1, "timeout");
    end

endmodule
